// File: rtl/rotary_enc_pkg.sv
// Shared types and helpers for the quadrature rotary encoder decoder.
package rotary_enc_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, GAP} out_state_t;

  // Polarity matches the stepper driver's direction input.
  typedef enum logic {DIR_CCW = 1'b0, DIR_CW = 1'b1} dir_t;

  typedef enum logic [1:0] {STEP_NONE, STEP_CW, STEP_CCW, STEP_ILLEGAL} step_t;

  localparam logic [1:0] DETENT_AB = 2'b11;

  localparam logic signed [3:0] ACC_MAX = 4'sd4;
  localparam logic signed [3:0] ACC_MIN = -4'sd4;

  function automatic step_t classify_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    step_t s;
    s = STEP_NONE;
    if ((prev_ab ^ cur_ab) == 2'b11) begin
      s = STEP_ILLEGAL;
    end else if (prev_ab != cur_ab) begin
      case ({prev_ab, cur_ab})
        4'b11_10, 4'b10_00, 4'b00_01, 4'b01_11: s = STEP_CW;
        default:                                s = STEP_CCW;
      endcase
    end
    return s;
  endfunction

  // Away from the detent the accumulator never needs +4, so it fits 3 signed bits.
  function automatic logic signed [2:0] sat_acc(input logic signed [3:0] v);
    logic signed [2:0] r;
    if (v > 4'sd3)        r = 3'sd3;
    else if (v < ACC_MIN) r = 3'b100;
    else                  r = v[2:0];
    return r;
  endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchroniser plus hold-time debounce filter for one encoder channel.
module enc_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 5000
) (
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: defaults first so no path leaves a combinational output unassigned (no latches).
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) filt_d = sync2_q;
      else                   cnt_d  = cnt_q + 1'b1;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/rotary_encoder_decoder.sv
// Quadrature encoder to cw/ccw detent pulses with a mandatory low gap.
// Define ENC_POSITION_EN to build the signed detent position counter.
module rotary_encoder_decoder
  import rotary_enc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 5000,
  parameter int unsigned PULSE_CYCLES    = 150000,
  parameter int unsigned GAP_CYCLES      = 50000,
  parameter int unsigned POS_WIDTH       = 16
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  input  logic                        enc_a,
  input  logic                        enc_b,
  output logic                        cw,
  output logic                        ccw,
  output logic                        err,
  output logic signed [POS_WIDTH-1:0] position
);

  localparam int unsigned TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

  logic filt_a, filt_b;

  enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .raw_i    (enc_a),
    .filt_o   (filt_a)
  );

  enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .raw_i    (enc_b),
    .filt_o   (filt_b)
  );

  logic [1:0]        ab, prev_ab_q;
  step_t             step;
  logic signed [2:0] acc_q, acc_d;
  logic signed [3:0] acc_sum;
  logic              evt_q, evt_d, err_q, err_d;
  dir_t              evt_dir_q, evt_dir_d;

  assign ab   = {filt_a, filt_b};
  assign step = classify_step(prev_ab_q, ab);

  always_comb begin
    acc_sum   = {acc_q[2], acc_q};
    acc_d     = acc_q;
    evt_d     = 1'b0;
    evt_dir_d = DIR_CW;
    err_d     = 1'b0;
    case (step)
      STEP_CW, STEP_CCW: begin
        acc_sum = (step == STEP_CW) ? acc_sum + 4'sd1 : acc_sum - 4'sd1;
        if (ab == DETENT_AB) begin
          acc_d = '0;
          if (acc_sum >= ACC_MAX) begin
            evt_d     = 1'b1;
            evt_dir_d = DIR_CW;
          end else if (acc_sum <= ACC_MIN) begin
            evt_d     = 1'b1;
            evt_dir_d = DIR_CCW;
          end
        end else begin
          acc_d = sat_acc(acc_sum);
        end
      end
      STEP_ILLEGAL: begin
        err_d = 1'b1;
        acc_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      prev_ab_q <= DETENT_AB;
      acc_q     <= '0;
      evt_q     <= 1'b0;
      evt_dir_q <= DIR_CW;
      err_q     <= 1'b0;
    end else begin
      prev_ab_q <= ab;
      acc_q     <= acc_d;
      evt_q     <= evt_d;
      evt_dir_q <= evt_dir_d;
      err_q     <= err_d;
    end
  end

  out_state_t    state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  dir_t          dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic          pend_valid_q, pend_valid_d;
  logic          cw_q, ccw_q;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      dir_q        <= DIR_CW;
      pend_valid_q <= 1'b0;
      pend_dir_q   <= DIR_CW;
      cw_q         <= 1'b0;
      ccw_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      pend_valid_q <= pend_valid_d;
      pend_dir_q   <= pend_dir_d;
      cw_q         <= (state_q == PULSE) && (dir_q == DIR_CW);
      ccw_q        <= (state_q == PULSE) && (dir_q == DIR_CCW);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    pend_valid_d = pend_valid_q;
    pend_dir_d   = pend_dir_q;
    case (state_q)
      IDLE: begin
        // A fresh event outranks (and discards) whatever was pending.
        if (evt_q) begin
          state_d      = PULSE;
          dir_d        = evt_dir_q;
          pend_valid_d = 1'b0;
          cnt_d        = '0;
        end else if (pend_valid_q) begin
          state_d      = PULSE;
          dir_d        = pend_dir_q;
          pend_valid_d = 1'b0;
          cnt_d        = '0;
        end
      end
      PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (evt_q && (state_q != IDLE)) begin
      pend_valid_d = 1'b1;
      pend_dir_d   = evt_dir_q;
    end
  end

  assign cw  = cw_q;
  assign ccw = ccw_q;
  assign err = err_q;

`ifdef ENC_POSITION_EN
  logic signed [POS_WIDTH-1:0] pos_q;

  // Counts every decoded detent, including ones the output FSM drops.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      pos_q <= '0;
    end else if (evt_d) begin
      pos_q <= (evt_dir_d == DIR_CW) ? pos_q + POS_WIDTH'(1) : pos_q - POS_WIDTH'(1);
    end
  end

  assign position = pos_q;
`else
  assign position = '0;
`endif

endmodule

// File: tb/tb_rotary_encoder_decoder.sv
// Scoreboard bench for rotary_encoder_decoder against a Gray-index reference model.
module tb_rotary_encoder_decoder;
  import rotary_enc_pkg::*;

  localparam int D  = 4;
  localparam int P  = 8;
  localparam int G  = 4;
  localparam int PW = 16;

  logic                 CLOCK_50 = 1'b0;
  logic                 reset_n  = 1'b0;
  logic                 enc_a    = 1'b1;
  logic                 enc_b    = 1'b1;
  logic                 cw, ccw, err;
  logic signed [PW-1:0] position;

  rotary_encoder_decoder #(
    .DEBOUNCE_CYCLES (D),
    .PULSE_CYCLES    (P),
    .GAP_CYCLES      (G),
    .POS_WIDTH       (PW)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .enc_a    (enc_a),
    .enc_b    (enc_b),
    .cw       (cw),
    .ccw      (ccw),
    .err      (err),
    .position (position)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    dir_t dir;
    int   rise;
  } pulse_t;

  pulse_t exp_pulse[$];
  int     exp_err[$];

  logic [1:0] m_ab;
  int         m_acc, m_pos, m_idle_from;
  bit         m_pend;
  dir_t       m_pend_dir;

  function automatic int gray_idx(input logic [1:0] ab);
    case (ab)
      2'b11:   return 0;
      2'b10:   return 1;
      2'b00:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gray_ab(input int idx);
    case (idx % 4)
      0:       return 2'b11;
      1:       return 2'b10;
      2:       return 2'b00;
      default: return 2'b01;
    endcase
  endfunction

  function automatic void model_reset();
    m_ab        = 2'b11;
    m_acc       = 0;
    m_pos       = 0;
    m_idle_from = 0;
    m_pend      = 0;
    m_pend_dir  = DIR_CW;
  endfunction

  // The output path goes idle at m_idle_from; a held request starts one cycle later.
  function automatic void serve_pending(input int upto);
    if (m_pend && m_idle_from < upto) begin
      exp_pulse.push_back('{dir: m_pend_dir, rise: m_idle_from + 2});
      m_idle_from = m_idle_from + 1 + P + G;
      m_pend      = 0;
    end
  endfunction

  function automatic void model_event(input int te, input dir_t d);
    serve_pending(te);
    m_pos = m_pos + ((d == DIR_CW) ? 1 : -1);
    if (te >= m_idle_from) begin
      exp_pulse.push_back('{dir: d, rise: te + 2});
      m_idle_from = te + 1 + P + G;
      m_pend      = 0;
    end else begin
      m_pend     = 1;
      m_pend_dir = d;
    end
  endfunction

  // c0: first clock edge that samples the final raw level of this step.
  function automatic void model_step(input logic [1:0] nab, input int c0);
    int te, delta;
    te    = c0 + D + 2;
    delta = (gray_idx(nab) - gray_idx(m_ab) + 4) % 4;
    m_ab  = nab;
    if (delta == 2) begin
      exp_err.push_back(te);
      m_acc = 0;
    end else if (delta != 0) begin
      m_acc = (delta == 1) ? ((m_acc < 4) ? m_acc + 1 : 4) : ((m_acc > -4) ? m_acc - 1 : -4);
      if (nab == 2'b11) begin
        if (m_acc == 4)       model_event(te, DIR_CW);
        else if (m_acc == -4) model_event(te, DIR_CCW);
        m_acc = 0;
      end
    end
  endfunction

  task automatic tick();
    @(negedge CLOCK_50);
    serve_pending(cyc + 7);
  endtask

  task automatic drive(input logic [1:0] nab, input bit glitch, input int hold);
    tick();
    if (glitch && $countones(nab ^ m_ab) == 1) begin
      {enc_a, enc_b} = nab;
      repeat (2) tick();
      {enc_a, enc_b} = m_ab;
      repeat (2) tick();
    end
    {enc_a, enc_b} = nab;
    model_step(nab, cyc + 1);
    repeat (hold) tick();
  endtask

  task automatic cw_detent(input bit glitch, input int hold);
    for (int i = 1; i <= 4; i++) drive(gray_ab(gray_idx(m_ab) + 1), glitch, hold);
  endtask

  task automatic ccw_detent(input bit glitch, input int hold);
    for (int i = 1; i <= 4; i++) drive(gray_ab(gray_idx(m_ab) + 3), glitch, hold);
  endtask

  task automatic drain(input string name);
    int n;
    logic signed [PW-1:0] pos_exp;
    n = 0;
    while ((m_pend || exp_pulse.size() != 0 || exp_err.size() != 0 || cw || ccw) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) check({name, "_drain_timeout"}, 1, 0);
    repeat (P + G + 2) tick();
`ifdef ENC_POSITION_EN
    pos_exp = PW'(m_pos);
`else
    pos_exp = '0;
`endif
    check({name, "_position"}, position, pos_exp);
  endtask

  initial begin : monitor
    bit prev_cw, prev_ccw;
    int hi_len;
    pulse_t p;
    int e;
    prev_cw  = 0;
    prev_ccw = 0;
    hi_len   = 0;
    forever begin
      @(negedge CLOCK_50);
      if (!reset_n) begin
        prev_cw  = 0;
        prev_ccw = 0;
        hi_len   = 0;
      end else begin
        if (cw && ccw) check("cw_ccw_exclusive", 1, 0);
        if ((cw && !prev_cw) || (ccw && !prev_ccw)) begin
          if (exp_pulse.size() == 0) begin
            check("unexpected_pulse", 1, 0);
          end else begin
            p = exp_pulse.pop_front();
            check("pulse_dir", cw ? 1 : 0, p.dir);
            check("pulse_rise_cycle", cyc, p.rise);
          end
          hi_len = 0;
        end
        if (cw || ccw) hi_len++;
        if ((!cw && prev_cw) || (!ccw && prev_ccw)) check("pulse_width", hi_len, P);
        if (err) begin
          if (exp_err.size() == 0) begin
            check("unexpected_err", 1, 0);
          end else begin
            e = exp_err.pop_front();
            check("err_cycle", cyc, e);
          end
        end
        prev_cw  = cw;
        prev_ccw = ccw;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  n;
    bit  seen;
    int  dir_run;
    bit  run_cw;
    model_reset();

    repeat (3) @(negedge CLOCK_50);
    check("reset_cw", cw, 0);
    check("reset_ccw", ccw, 0);
    check("reset_err", err, 0);
    check("reset_position", position, 0);
    reset_n = 1'b1;
    repeat (3) tick();

    cw_detent(0, 20);
    drain("clean_cw");

    ccw_detent(1, 20);
    drain("glitchy_ccw");

    drive(2'b10, 0, 20);
    drive(2'b00, 0, 20);
    drive(2'b10, 0, 20);
    drive(2'b11, 0, 20);
    cw_detent(0, 20);
    drain("half_detent");

    drive(2'b00, 0, 20);
    drive(2'b01, 0, 20);
    drive(2'b11, 0, 20);
    cw_detent(0, 20);
    drain("illegal_jump");

    for (int k = 0; k < 3; k++) cw_detent(0, 1);
    drain("fast_cw");

    drive(2'b10, 0, 20);
    drive(2'b00, 0, 20);
    drive(2'b01, 0, 20);
    drive(2'b11, 0, 1);
    seen = 0;
    n    = 0;
    while (!seen && n < 50) begin
      tick();
      seen = cw;
      n++;
    end
    check("midpulse_cw_seen", seen, 1);
    repeat (3) tick();
    #2 reset_n = 1'b0;
    #1;
    check("midpulse_reset_cw", cw, 0);
    check("midpulse_reset_ccw", ccw, 0);
    check("midpulse_reset_err", err, 0);
    check("midpulse_reset_position", position, 0);
    exp_pulse.delete();
    exp_err.delete();
    model_reset();
    repeat (3) @(negedge CLOCK_50);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_reset_outputs", {cw, ccw, err}, 0);
    end
    cw_detent(0, 20);
    drain("post_reset_cw");

    dir_run = 0;
    run_cw  = 1;
    for (int k = 0; k < 80; k++) begin
      if (dir_run == 0) begin
        dir_run = $urandom_range(1, 8);
        run_cw  = $urandom_range(0, 1);
      end
      dir_run--;
      if ($urandom_range(0, 19) == 0)
        drive(m_ab ^ 2'b11, 0, $urandom_range(4, 20));
      else
        drive(gray_ab(gray_idx(m_ab) + (run_cw ? 1 : 3)), bit'($urandom_range(0, 1)),
              $urandom_range(4, 30));
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
